// File: rtl/l2_bus_responder.sv
// l2_bus_responder: block-granular L2 stand-in that answers bus_ctrl load/store requests after a latency
// Ports:
//   CLK, nRST         clock, synchronous active-low reset
//   l2_load/l2_store  request strobes, held until ACCESS (both high is an error)
//   l2_addr           byte address; block index taken above the in-block offset
//   l2_store_value    write block, word 0 in the LSBs
//   l2_load_value     read block, nonzero only during ACCESS of a load
//   l2_state          FREE=0, BUSY=1, ACCESS=2, ERROR=3
// Optional: define L2_RESP_RAND_LAT_EN for LFSR-driven latency (1..LAT_RANGE) instead of LATENCY.
module l2_bus_responder #(
    parameter int          BLOCK_SIZE_WORDS = 2,
    parameter int          WORD_W           = 32,
    parameter int          DEPTH            = 16,
    parameter int          LATENCY          = 3,
    parameter int          LAT_RANGE        = 10,
    parameter logic [15:0] LFSR_SEED        = 16'hACE1
) (
    input  logic                               CLK,
    input  logic                               nRST,
    input  logic                               l2_load,
    input  logic                               l2_store,
    input  logic [31:0]                        l2_addr,
    input  logic [BLOCK_SIZE_WORDS*WORD_W-1:0] l2_store_value,
    output logic [BLOCK_SIZE_WORDS*WORD_W-1:0] l2_load_value,
    output logic [1:0]                         l2_state
);
    localparam int DW  = BLOCK_SIZE_WORDS * WORD_W;
    localparam int OFS = $clog2(DW / 8);
    localparam int IW  = $clog2(DEPTH);

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT = 2'd1, S_DONE = 2'd2, S_ERR = 2'd3} state_t;

    state_t          state;
    logic [15:0]     cnt;
    logic [15:0]     lat;
    logic            is_store;
    logic [IW-1:0]   idx;
    logic [DW-1:0]   data;
    logic [DW-1:0]   mem [DEPTH];
    logic [OFS-1:0]  unused_ofs;

    wire req = l2_load || l2_store;
    wire oor = l2_addr[31:OFS+IW] != '0;

    assign unused_ofs = l2_addr[OFS-1:0];
    assign l2_state   = state;

`ifdef L2_RESP_RAND_LAT_EN
    localparam int unused_par = LATENCY;
    logic [15:0] lfsr;
    // Fibonacci taps 16,14,13,11; free-running so latency depends on arrival time
    always_ff @(posedge CLK) begin
        if (!nRST) lfsr <= LFSR_SEED;
        else lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end
    assign lat = lfsr % 16'(LAT_RANGE) + 16'd1;
`else
    localparam int unused_par = LAT_RANGE + int'(LFSR_SEED);
    assign lat = 16'(LATENCY);
`endif

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state         <= S_IDLE;
            cnt           <= '0;
            is_store      <= 1'b0;
            idx           <= '0;
            data          <= '0;
            l2_load_value <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if ((l2_load && l2_store) || (req && oor)) begin
                        state <= S_ERR;
                    end else if (req) begin
                        state    <= S_WAIT;
                        is_store <= l2_store;
                        idx      <= l2_addr[OFS+IW-1:OFS];
                        data     <= l2_store_value;
                        cnt      <= lat;
                    end
                end
                S_WAIT: begin
                    // abort wins over completion so a dropped request never writes
                    if (!req) begin
                        state <= S_IDLE;
                        cnt   <= '0;
                    end else if (cnt == 16'd1) begin
                        state <= S_DONE;
                        cnt   <= '0;
                        if (!is_store) l2_load_value <= mem[idx];
                    end else begin
                        cnt <= cnt - 16'd1;
                    end
                end
                S_DONE: begin
                    state         <= S_IDLE;
                    l2_load_value <= '0;
                    if (is_store) mem[idx] <= data;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_l2_bus_responder.sv
// tb_l2_bus_responder: randomized self-checking bench against a block-store and latency model
module tb_l2_bus_responder;
    localparam int          DW        = 64;
    localparam int          DEPTH     = 16;
    localparam int          LATENCY   = 3;
    localparam int          LAT_RANGE = 10;
    localparam logic [15:0] SEED      = 16'hACE1;

    logic          CLK = 1'b0;
    logic          nRST = 1'b0;
    logic          l2_load = 1'b0;
    logic          l2_store = 1'b0;
    logic [31:0]   l2_addr = '0;
    logic [DW-1:0] l2_store_value = '0;
    logic [DW-1:0] l2_load_value;
    logic [1:0]    l2_state;

    int            passed = 0;
    int            total = 0;
    int            last_lat;
    logic [DW-1:0] model_mem [DEPTH];
    logic [15:0]   m_lfsr;

    always #5 CLK = ~CLK;

    l2_bus_responder #(
        .BLOCK_SIZE_WORDS(2), .WORD_W(32), .DEPTH(DEPTH),
        .LATENCY(LATENCY), .LAT_RANGE(LAT_RANGE), .LFSR_SEED(SEED)
    ) dut (
        .CLK(CLK), .nRST(nRST), .l2_load(l2_load), .l2_store(l2_store),
        .l2_addr(l2_addr), .l2_store_value(l2_store_value),
        .l2_load_value(l2_load_value), .l2_state(l2_state)
    );

    // reference LFSR: polynomial x^16+x^14+x^13+x^11+1, new bit = parity of tapped bits
    always @(posedge CLK) m_lfsr <= !nRST ? SEED : {m_lfsr[14:0], ^(m_lfsr & 16'hB400)};

    function automatic int exp_lat();
`ifdef L2_RESP_RAND_LAT_EN
        return int'(m_lfsr) % LAT_RANGE + 1;
`else
        return LATENCY;
`endif
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic do_reset(input int cycles);
        nRST = 1'b0;
        l2_load = 1'b0;
        l2_store = 1'b0;
        repeat (cycles) @(posedge CLK);
        @(negedge CLK);
        nRST = 1'b1;
        for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
    endtask

    task automatic xfer(input logic ld, input logic st, input logic [31:0] a, input logic [DW-1:0] d);
        int n;
        int lat;
        bit wz;
        bit err;
        int ix;
        ix  = int'(a[6:3]);
        err = (ld && st) || (a[31:7] != 0);
        lat = exp_lat();
        l2_load = ld;
        l2_store = st;
        l2_addr = a;
        l2_store_value = d;
        n = 0;
        wz = 1'b1;
        do begin
            @(posedge CLK);
            @(negedge CLK);
            n++;
            if (l2_state == 2'd1 && l2_load_value != '0) wz = 1'b0;
        end while (l2_state == 2'd1 && n < 40);
        last_lat = n;
        if (err) begin
            check("err_state", 64'(l2_state), 64'd3);
            check("err_cycles", 64'(n), 64'd1);
            check("err_lv", l2_load_value, 64'd0);
        end else begin
            check("access_state", 64'(l2_state), 64'd2);
            check("latency", 64'(n), 64'(lat + 1));
            check("load_value", l2_load_value, ld ? model_mem[ix] : 64'd0);
            check("wait_lv_zero", 64'(wz), 64'd1);
            if (st) model_mem[ix] = d;
        end
        l2_load = 1'b0;
        l2_store = 1'b0;
        @(posedge CLK);
        @(negedge CLK);
        check("free_after", 64'(l2_state), 64'd0);
        check("lv_after", l2_load_value, 64'd0);
    endtask

    initial begin
        int lat;
        int r;
        logic [31:0] a;
        do_reset(2);
        check("reset_state", 64'(l2_state), 64'd0);
        check("reset_lv", l2_load_value, 64'd0);

        xfer(1, 0, 32'h00, '0);
`ifndef L2_RESP_RAND_LAT_EN
        check("first_latency_4", 64'(last_lat), 64'd4);
`endif
        xfer(0, 1, 32'h18, 64'hDEADBEEF_CAFEF00D);
        xfer(1, 0, 32'h18, '0);
        xfer(1, 0, 32'h10, '0);

        xfer(1, 1, 32'h08, 64'h1234_5678_9ABC_DEF0);
        xfer(1, 0, 32'h08, '0);
        xfer(1, 0, 32'h100, '0);
        xfer(1, 0, 32'h18, '0);

        // abort: drop the store in the second cycle after acceptance
        lat = exp_lat();
        l2_store = 1'b1;
        l2_addr = 32'h20;
        l2_store_value = 64'h1;
        @(posedge CLK); @(negedge CLK);
        @(posedge CLK); @(negedge CLK);
        check("abort_c2_state", 64'(l2_state), lat >= 2 ? 64'd1 : 64'd2);
        if (lat < 2) model_mem[4] = 64'h1;
        l2_store = 1'b0;
        @(posedge CLK); @(negedge CLK);
        check("abort_free", 64'(l2_state), 64'd0);
        xfer(1, 0, 32'h20, '0);

        // reset during the first WAIT cycle discards the store
        l2_store = 1'b1;
        l2_addr = 32'h28;
        l2_store_value = 64'hFFFF_0000_AAAA_5555;
        @(posedge CLK); @(negedge CLK);
        check("mid_wait_busy", 64'(l2_state), 64'd1);
        nRST = 1'b0;
        l2_store = 1'b0;
        @(posedge CLK); @(negedge CLK);
        check("mid_wait_reset_free", 64'(l2_state), 64'd0);
        check("mid_wait_reset_lv", l2_load_value, 64'd0);
        nRST = 1'b1;
        for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
        xfer(1, 0, 32'h28, '0);

        for (int i = 0; i < 120; i++) begin
            r = $urandom_range(0, 9);
            a = 32'($urandom_range(0, 127));
            if (r == 0) xfer(1, 0, $urandom | 32'h80, '0);
            else if (r == 1) xfer(1, 1, a, {$urandom, $urandom});
            else xfer(r < 6, r >= 6, a, {$urandom, $urandom});
        end

`ifdef L2_RESP_RAND_LAT_EN
        begin
            int trace [10];
            for (int i = 0; i < 200; i++) begin
                xfer(1, 0, 32'($urandom_range(0, 127)), '0);
                total++;
                assert (last_lat >= 2 && last_lat <= 11) passed++;
                else $error("FAIL lat_range: observed %0d expected 2..11", last_lat);
            end
            do_reset(2);
            for (int i = 0; i < 10; i++) begin
                xfer(1, 0, 32'(i * 8), '0);
                trace[i] = last_lat;
            end
            do_reset(2);
            for (int i = 0; i < 10; i++) begin
                xfer(1, 0, 32'(i * 8), '0);
                check("trace_repeat", 64'(last_lat), 64'(trace[i]));
            end
        end
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
